// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) reusing one bank of add-3 correctors per bit.
// Define BIN2BCD_FAST_EN to merge the correct and shift steps into a single cycle per bit.
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CW = $clog2(W + 1);
    localparam int AW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADJ  = 2'd1,
        SHF  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    sh_r;
    logic [AW-1:0]   acc_r;
    logic [CW-1:0]   cnt_r;
    logic            ovf_sticky_r;
    logic [AW-1:0]   adj_s;
    logic            last_bit_s;
    logic            busy_r;
    logic            done_r;
    logic [AW-1:0]   bcd_r;
    logic            ovf_r;

    // Every digit >= 5 gets +3; the 4-bit sum wraps modulo 16 by construction.
    function automatic logic [AW-1:0] add3_all(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        for (int d = 0; d < DIGITS; d++) begin
            if (a[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = a[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = a[4*d +: 4];
            end
        end
        return r;
    endfunction

    // Correction bank and end-of-operand detect shared by both schedules.
    always_comb begin
        adj_s      = add3_all(acc_r);
        last_bit_s = (cnt_r == CW'(1));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ADJ;
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef BIN2BCD_FAST_EN
            ADJ: begin
                if (last_bit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ADJ;
                end
            end
`else
            ADJ: begin
                state_s = SHF;
            end
`endif
            SHF: begin
                if (last_bit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ADJ;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_r == DONE);
        end
    end

    // Operand/accumulator datapath and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r         <= '0;
            acc_r        <= '0;
            cnt_r        <= '0;
            ovf_sticky_r <= 1'b0;
            bcd_r        <= '0;
            ovf_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sh_r         <= bin;
                        acc_r        <= '0;
                        ovf_sticky_r <= 1'b0;
                        cnt_r        <= CW'(W);
                    end else begin
                        sh_r <= sh_r;
                    end
                end
`ifdef BIN2BCD_FAST_EN
                ADJ: begin
                    {acc_r, sh_r} <= {adj_s[AW-2:0], sh_r, 1'b0};
                    ovf_sticky_r  <= ovf_sticky_r | adj_s[AW-1];
                    cnt_r         <= cnt_r - CW'(1);
                end
`else
                ADJ: begin
                    acc_r <= adj_s;
                end
`endif
                SHF: begin
                    // Any 1 leaving the top digit means the value needs more digits.
                    {acc_r, sh_r} <= {acc_r[AW-2:0], sh_r, 1'b0};
                    ovf_sticky_r  <= ovf_sticky_r | acc_r[AW-1];
                    cnt_r         <= cnt_r - CW'(1);
                end
                DONE: begin
                    bcd_r <= acc_r;
                    ovf_r <= ovf_sticky_r;
                end
                default: begin
                    sh_r <= sh_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (3-digit and 2-digit instances).
module tb_bin2bcd_seq;

    localparam int W = 8;
`ifdef BIN2BCD_FAST_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = 2 * W + 1;
`endif
    localparam int PER = LAT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [7:0]  bin_a, bin_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
    );

    bin2bcd_seq #(.W(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] dec3(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Sample i is taken just after edge i, where edge 0 accepts start.
    task automatic convert(input int sel, input logic [7:0] v,
                           output int lat, output int busy_n, output int done_n);
        lat = -1;
        busy_n = 0;
        done_n = 0;
        if (sel == 0) begin bin_a = v; start_a = 1'b1; end
        else begin bin_b = v; start_b = 1'b1; end
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < LAT + 6; i++) begin
            if ((sel == 0) ? busy_a : busy_b) busy_n++;
            if ((sel == 0) ? done_a : done_b) begin
                done_n++;
                if (lat < 0) lat = i;
            end
            step();
        end
    endtask

    initial begin
        int lat, bn, dn, gap, found;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = 8'd0; bin_b = 8'd0;
        step();
        step();
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_bcd",  32'(bcd_a),  32'd0);
        chk("rst_ovf",  32'(ovf_a),  32'd0);
        rst = 1'b0;
        step();

        // Full scale
        convert(0, 8'd255, lat, bn, dn);
        chk("fs_lat",  32'(lat), 32'(LAT));
        chk("fs_busy", 32'(bn),  32'(LAT));
        chk("fs_done", 32'(dn),  32'd1);
        chk("fs_bcd",  32'(bcd_a), 32'h255);
        chk("fs_ovf",  32'(ovf_a), 32'd0);

        // Zero and single digit
        convert(0, 8'd0, lat, bn, dn);
        chk("zero_done", 32'(dn), 32'd1);
        chk("zero_bcd",  32'(bcd_a), 32'h000);
        convert(0, 8'd9, lat, bn, dn);
        chk("nine_done", 32'(dn), 32'd1);
        chk("nine_bcd",  32'(bcd_a), 32'h009);

        // Second start during a conversion is dropped
        bin_a = 8'd59; start_a = 1'b1;
        step();
        start_a = 1'b0;
        dn = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            if (i == 5) begin bin_a = 8'd13; start_a = 1'b1; end
            if (i == 6) start_a = 1'b0;
            step();
            if (done_a) dn++;
        end
        chk("ign_done", 32'(dn), 32'd1);
        chk("ign_bcd",  32'(bcd_a), 32'h059);

        // Overflow on the two-digit instance, then a clean result
        convert(1, 8'd100, lat, bn, dn);
        chk("ovf_lat", 32'(lat), 32'(LAT));
        chk("ovf_bcd", 32'(bcd_b), 32'h00);
        chk("ovf_flag", 32'(ovf_b), 32'd1);
        convert(1, 8'd42, lat, bn, dn);
        chk("post_bcd", 32'(bcd_b), 32'h42);
        chk("post_ovf", 32'(ovf_b), 32'd0);

        // Reset at edge 6 of a conversion of 200
        bin_a = 8'd200; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_busy", 32'(busy_a), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_busy", 32'(busy_a), 32'd0);
        chk("mr_bcd",  32'(bcd_a),  32'd0);
        chk("mr_done", 32'(done_a), 32'd0);
        dn = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (done_a) dn++;
        end
        chk("mr_nodone", 32'(dn), 32'd0);
        convert(0, 8'd23, lat, bn, dn);
        chk("mr_lat", 32'(lat), 32'(LAT));
        chk("mr_new", 32'(bcd_a), 32'h023);

        // Back-to-back sweep with start held high
        bin_a = 8'd0; start_a = 1'b1;
        step();
        gap = 0;
        for (int v = 0; v < 256; v++) begin
            found = 0;
            for (int k = 0; k < PER + 2 && found == 0; k++) begin
                step();
                gap++;
                if (done_a) found = 1;
            end
            chk("sw_found", 32'(found), 32'd1);
            chk("sw_gap", 32'(gap), (v == 0) ? 32'(LAT) : 32'(PER));
            chk("sw_bcd", 32'(bcd_a), 32'(dec3(v)));
            gap = 0;
            if (v == 255) start_a = 1'b0;
            else bin_a = 8'(v + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
